// File: rtl/rob_pkg.sv
// rob_pkg: shared instruction-type codes, state encoding and sizing defaults
// for the dual-commit reorder buffer.
package rob_pkg;
  localparam int ROB_DEPTH_DEF = 16;
  typedef enum logic [2:0] {
    T_ALU    = 3'd0,
    T_LOAD   = 3'd1,
    T_STORE  = 3'd2,
    T_BRANCH = 3'd3,
    T_JAL    = 3'd4
  } iss_type_e;
  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } rob_state_e;
  function automatic logic dual_ok(input logic [2:0] t);
    return t == T_ALU || t == T_LOAD || t == T_JAL;
  endfunction
endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: decides whether the head (slot 0) and the entry behind it
// (slot 1) retire this cycle.
module rob_commit_select
  import rob_pkg::*;
(
  input  logic       en,
  input  rob_state_e state,
  input  logic       head_valid,
  input  logic       head_ready,
  input  logic [2:0] head_type,
  input  logic       next_valid,
  input  logic       next_ready,
  input  logic [2:0] next_type,
  output logic       go0,
  output logic       go1
);
  always_comb begin
    go0 = en && state == S_RUN && head_valid && head_ready;
    go1 = go0 && dual_ok(head_type) && next_valid && next_ready && dual_ok(next_type);
  end
endmodule

// File: rtl/rob_dual_commit.sv
// rob_dual_commit: reorder buffer retiring up to two entries per cycle, with a
// store release handshake and a mispredict flush.
module rob_dual_commit
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int NUM_WB    = 3,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    iss_valid,
  output logic                    iss_ready,
  output logic [TAG_W-1:0]        iss_tag,
  input  logic [4:0]              iss_rd,
  input  logic [2:0]              iss_type,
  input  logic [31:0]             iss_pc,
  input  logic                    iss_pred_taken,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*32-1:0]    wb_value,
  input  logic [NUM_WB-1:0]       wb_taken,
  input  logic [NUM_WB*32-1:0]    wb_target,
  output logic [1:0]              cm_valid,
  output logic [9:0]              cm_rd,
  output logic [63:0]             cm_value,
  output logic [2*TAG_W-1:0]      cm_tag,
  output logic                    st_commit,
  input  logic                    st_done,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic [TAG_W:0]          count
);
  rob_state_e state, state_nx;
  logic [TAG_W-1:0] head, tail, head1;
  logic [ROB_DEPTH-1:0] valid, ready, taken_q, pred_q;
  logic [4:0] rd_q [ROB_DEPTH];
  logic [2:0] type_q [ROB_DEPTH];
  logic [31:0] pc_q [ROB_DEPTH];
  logic [31:0] value_q [ROB_DEPTH];
  logic [31:0] target_q [ROB_DEPTH];
  logic [NUM_WB-1:0] wb_hit;
  logic iss_fire, go0, go1, is_st, is_br, mispred, st_ret, ret0;
  logic [1:0] n_ret;

  always_comb begin
    head1 = head + TAG_W'(1);
    iss_ready = count < (TAG_W+1)'(ROB_DEPTH) && state == S_RUN;
    iss_tag = tail;
    iss_fire = rdy_in && iss_valid && iss_ready;
    wb_hit = '0;
    for (int i = 0; i < NUM_WB; i++)
      wb_hit[i] = rdy_in && wb_valid[i] && valid[wb_tag[i*TAG_W +: TAG_W]] && !ready[wb_tag[i*TAG_W +: TAG_W]];
    is_st = type_q[head] == T_STORE;
    is_br = type_q[head] == T_BRANCH;
    mispred = is_br && taken_q[head] != pred_q[head];
    st_ret = rdy_in && state == S_STORE_WAIT && st_done;
  end

  rob_commit_select u_sel (
    .en        (rdy_in),
    .state     (state),
    .head_valid(valid[head]),
    .head_ready(ready[head]),
    .head_type (type_q[head]),
    .next_valid(valid[head1]),
    .next_ready(ready[head1]),
    .next_type (type_q[head1]),
    .go0       (go0),
    .go1       (go1)
  );

  // A ready STORE at the head is announced but only retires once memory reports done.
  always_comb begin
    ret0 = (go0 && !is_st) || st_ret;
    n_ret = {1'b0, ret0} + {1'b0, go1};
    state_nx = !rdy_in ? state :
               (state == S_FLUSH || st_ret) ? S_RUN :
               (go0 && is_st) ? S_STORE_WAIT :
               (go0 && mispred) ? S_FLUSH : state;
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= S_RUN;
    else state <= state_nx;

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      ready <= '0;
      cm_valid <= '0;
      cm_rd <= '0;
      cm_value <= '0;
      cm_tag <= '0;
      st_commit <= 1'b0;
      flush <= 1'b0;
      flush_pc <= '0;
    end else begin
      cm_valid <= {go1, go0};
      st_commit <= go0 && is_st;
      flush <= go0 && mispred;
      if (go0) begin
        cm_rd <= {rd_q[head1], (is_st || is_br) ? 5'd0 : rd_q[head]};
        cm_value <= {value_q[head1], value_q[head]};
        cm_tag <= {head1, head};
      end
      if (go0 && mispred) flush_pc <= taken_q[head] ? target_q[head] : pc_q[head] + 32'd4;
      if (rdy_in && state == S_FLUSH) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        valid <= '0;
        ready <= '0;
      end else if (rdy_in) begin
        for (int i = 0; i < NUM_WB; i++)
          if (wb_hit[i]) ready[wb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
        if (ret0) valid[head] <= 1'b0;
        if (go1) valid[head1] <= 1'b0;
        if (iss_fire) begin
          valid[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          tail <= tail + TAG_W'(1);
        end
        head <= head + TAG_W'(n_ret);
        count <= count + (TAG_W+1)'(iss_fire) - (TAG_W+1)'(n_ret);
      end
    end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk_in) begin
    if (iss_fire) begin
      rd_q[tail] <= iss_rd;
      type_q[tail] <= iss_type;
      pc_q[tail] <= iss_pc;
      pred_q[tail] <= iss_pred_taken;
    end
    for (int i = 0; i < NUM_WB; i++)
      if (wb_hit[i]) begin
        value_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_value[i*32 +: 32];
        taken_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_taken[i];
        target_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_target[i*32 +: 32];
      end
  end
endmodule

// File: doc/rob_dual_commit.md
ROB_DUAL_COMMIT -- requirements
Module: rob_dual_commit

Interface
REQ-001 The block SHALL have parameter ROB_DEPTH, default 16, entry count (power of two, 4..64).
REQ-002 The block SHALL have parameter NUM_WB, default 3, number of write-back channels.
REQ-003 The block SHALL have parameter TAG_W, default $clog2(ROB_DEPTH), entry tag width.
REQ-004 clk_in  in  1  single clock, rising edge.
REQ-005 rst_in  in  1  reset, asynchronous, active-high.
REQ-006 rdy_in  in  1  low = pause: all state held; issue and write-back inputs ignored.
REQ-007 iss_valid in 1, iss_ready out 1, iss_tag out TAG_W: issue handshake; iss_tag = tail pointer.
REQ-008 iss_rd in 5, iss_type in 3, iss_pc in 32, iss_pred_taken in 1: issued entry fields.
REQ-009 wb_valid in NUM_WB, wb_tag in NUM_WB*TAG_W, wb_value in NUM_WB*32, wb_taken in NUM_WB, wb_target in NUM_WB*32: write-back channels.
REQ-010 cm_valid out 2, cm_rd out 2*5, cm_value out 2*32, cm_tag out 2*TAG_W: commit slots 0/1.
REQ-011 st_commit out 1, st_done in 1: store release pulse and memory completion.
REQ-012 flush out 1, flush_pc out 32: mispredict redirect; count out TAG_W+1: occupancy.

Function
REQ-013 Occupancy SHALL be tracked by a count register, so all ROB_DEPTH entries are usable; iss_ready = (count < ROB_DEPTH) && state==RUN, from registered state only.
REQ-014 Issue: iss_valid && iss_ready writes the entry at tail, clears ready, tail wraps modulo ROB_DEPTH.
REQ-015 Write-back: each wb_valid whose tag hits a valid, not-ready entry sets ready and stores value/taken/target; hits on invalid entries are ignored; same-tag collisions resolve to the highest channel index.
REQ-016 Latency: write-back at edge t makes the entry commit-eligible in cycle t+1; registered cm_* outputs are visible after edge t+1.
REQ-017 Slot 0 commits the head when it is valid and ready and state==RUN.
REQ-018 Slot 1 commits head+1 only when slot 0 commits, slot 0 is ALU/LOAD/JAL, and head+1 is valid, ready and ALU/LOAD/JAL.
REQ-019 cm_valid SHALL be one-cycle pulses; count updates by issued minus retired in the same edge.
REQ-020 States: RUN, STORE_WAIT, FLUSH.
REQ-021 RUN->STORE_WAIT when the head STORE is ready: st_commit pulses one cycle, cm_valid[0] pulses with cm_rd=0.
REQ-022 STORE_WAIT->RUN on st_done; the head retires on that edge; st_done in any other state is ignored.
REQ-023 RUN->FLUSH when the head BRANCH commits with taken != pred_taken: flush pulses next cycle; flush_pc = taken ? target : pc+4.
REQ-024 FLUSH clears all valid bits and head, tail and count; any same-cycle issue or write-back is dropped; FLUSH->RUN after one cycle.
REQ-025 A correctly predicted BRANCH retires in slot 0 only, with cm_rd=0.

Reset
REQ-026 Asserting rst_in (mid-operation included) SHALL immediately clear: state=RUN, head=tail=count=0, all valid/ready bits=0, cm_valid=0, st_commit=0, flush=0, flush_pc=0, cm_rd/cm_value/cm_tag=0.

Structure
REQ-027 Package rob_pkg SHALL hold the iss_type codes (ALU, LOAD, STORE, BRANCH, JAL), the state encoding and the ROB_DEPTH default.
REQ-028 Commit-slot eligibility logic SHALL be one combinational sub-module, rob_commit_select.

Verification
REQ-029 Issue 16 ALU entries -> iss_ready=0 and count=16; one write-back to the head -> cm_valid=01, then iss_ready=1.
REQ-030 Tags 3 and 4 ready with the head at 3 -> cm_valid=11 in the same cycle, cm_tag={4,3}.
REQ-031 STORE at the head becomes ready -> st_commit pulses once; head held; st_done 5 cycles later -> head advances.
REQ-032 BRANCH at pc 0x100 with pred_taken=0, wb_taken=1, target 0x200 -> flush=1, flush_pc=0x200, count=0 next cycle.
REQ-033 Two channels write back tag 2 in the same cycle -> channel 2's value is committed; rst_in asserted mid-STORE_WAIT -> all outputs 0 immediately.
REQ-034 Tail wraps 15->0 while the head wraps -> commit order preserved; rdy_in low for 3 cycles -> no state change.
